// File: rtl/parity_frame_rx.sv
// Serial frame receiver for the 3-bit parity link: reassembles
// start/data/parity/stop frames from qualified line bits, checks parity
// and stop bit, and hands completed words out on a valid/ready register.
module parity_frame_rx #(
  parameter int DATA_W     = 3,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shadow;
  logic              parity_bit;
  logic              start_seen;
  logic              shift_en;
  logic              parity_en;
  logic              frame_ok;
  logic              frame_bad;
  logic              accept;
  logic              load;
  logic              parity_mismatch;

  // The held word leaves when the consumer takes it; a finished frame may
  // refill the register in that same cycle, otherwise it is an overrun.
  assign accept          = valid_o && ready_i;
  assign load            = frame_ok && (!valid_o || accept);
  assign parity_mismatch = parity_bit != ((^shadow) ^ ODD_PARITY);

  // Frame state register; unqualified cycles leave it untouched via state_next.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the per-bit strobes for the datapath below.
  always_comb begin
    state_next = state;
    start_seen = 1'b0;
    shift_en   = 1'b0;
    parity_en  = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (bit_valid_i) begin
      case (state)
        IDLE: begin
          if (!bit_i) begin
            start_seen = 1'b1;
            state_next = DATA;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_IDX) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_en  = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          frame_ok   = bit_i;
          frame_bad  = !bit_i;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Shadow word and parity capture, kept apart from data_o so reception
  // can run while the previous word is still waiting to be taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bit_cnt    <= '0;
      shadow     <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (start_seen) begin
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shadow[bit_cnt] <= bit_i;
        bit_cnt         <= bit_cnt + CNT_W'(1);
      end
      if (parity_en) begin
        parity_bit <= bit_i;
      end
    end
  end

  // Output register and one-cycle error pulses, all updated on the edge
  // that samples the stop bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o <= frame_bad;
      overrun_o   <= frame_ok && !load;
      if (load) begin
        data_o       <= shadow;
        parity_err_o <= parity_mismatch;
        valid_o      <= 1'b1;
      end else if (accept) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: scenario tasks drive frames and
// check pulses inline; delivered words are matched against a scoreboard.
module tb_parity_frame_rx;

  typedef struct packed {
    logic [2:0] data;
    logic       perr;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       bit_i;
  logic       bit_valid_i;
  logic       ready_i;
  logic [2:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;

  logic       odd_bit;
  logic       odd_bit_valid;
  logic       odd_ready;
  logic [2:0] odd_data;
  logic       odd_valid;
  logic       odd_perr;
  logic       odd_ferr;
  logic       odd_ovr;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  parity_frame_rx #(.DATA_W(3), .ODD_PARITY(1'b0)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  parity_frame_rx #(.DATA_W(3), .ODD_PARITY(1'b1)) dut_odd (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bit_i        (odd_bit),
    .bit_valid_i  (odd_bit_valid),
    .data_o       (odd_data),
    .valid_o      (odd_valid),
    .ready_i      (odd_ready),
    .parity_err_o (odd_perr),
    .frame_err_o  (odd_ferr),
    .overrun_o    (odd_ovr)
  );

  // Scoreboard monitor: a handshake seen at the falling edge completes on the
  // next rising edge, so the delivered word is compared here.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: got data=%b perr=%b, no word expected", data_o, parity_err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_o !== e.data || parity_err_o !== e.perr) begin
          bad++;
          $display("[TB] FAIL sb_word: got data=%b perr=%b want data=%b perr=%b",
                   data_o, parity_err_o, e.data, e.perr);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    bit_i       = b;
    bit_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    bit_valid_i = 1'b0;
    bit_i       = 1'b1;
  endtask

  // Sends bits[5] first; bits[0] is the stop bit.
  task automatic send_frame(input logic [5:0] bits);
    for (int i = 5; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic send_head(input logic [5:0] bits);
    for (int i = 5; i >= 1; i--) send_bit(bits[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    idle(2);
    chk("rst_data", data_o, 3'b000);
    chk("rst_valid", {2'b0, valid_o}, 3'b000);
    chk("rst_perr", {2'b0, parity_err_o}, 3'b000);
    chk("rst_ferr", {2'b0, frame_err_o}, 3'b000);
    chk("rst_ovr", {2'b0, overrun_o}, 3'b000);
    chk("rst_odd_valid", {2'b0, odd_valid}, 3'b000);
    rst_ni = 1'b1;
    idle(1);
  endtask

  task automatic test_clean_frame;
    ready_i = 1'b1;
    sb.push_back('{data: 3'b011, perr: 1'b0});
    send_frame(6'b011001);
    chk("clean_valid", {2'b0, valid_o}, 3'b001);
    chk("clean_data", data_o, 3'b011);
    chk("clean_perr", {2'b0, parity_err_o}, 3'b000);
    chk("clean_ferr", {2'b0, frame_err_o}, 3'b000);
    idle(1);
    chk("clean_valid_drop", {2'b0, valid_o}, 3'b000);
  endtask

  task automatic test_parity_error;
    sb.push_back('{data: 3'b111, perr: 1'b1});
    send_frame(6'b011101);
    chk("perr_valid", {2'b0, valid_o}, 3'b001);
    chk("perr_flag", {2'b0, parity_err_o}, 3'b001);
    chk("perr_data", data_o, 3'b111);
    idle(1);
  endtask

  task automatic test_odd_parity;
    for (int i = 5; i >= 0; i--) begin
      logic [5:0] f;
      f             = 6'b011101;
      odd_bit       = f[i];
      odd_bit_valid = 1'b1;
      @(posedge clk_i);
      #1;
      odd_bit_valid = 1'b0;
      odd_bit       = 1'b1;
    end
    chk("odd_valid", {2'b0, odd_valid}, 3'b001);
    chk("odd_data", odd_data, 3'b111);
    chk("odd_perr", {2'b0, odd_perr}, 3'b000);
    idle(1);
    chk("odd_valid_drop", {2'b0, odd_valid}, 3'b000);
  endtask

  task automatic test_frame_error;
    send_frame(6'b001010);
    chk("ferr_pulse", {2'b0, frame_err_o}, 3'b001);
    chk("ferr_valid", {2'b0, valid_o}, 3'b000);
    chk("ferr_ovr", {2'b0, overrun_o}, 3'b000);
    idle(1);
    chk("ferr_once", {2'b0, frame_err_o}, 3'b000);
    sb.push_back('{data: 3'b100, perr: 1'b0});
    send_frame(6'b000111);
    chk("ferr_next_valid", {2'b0, valid_o}, 3'b001);
    chk("ferr_next_data", data_o, 3'b100);
    chk("ferr_next_perr", {2'b0, parity_err_o}, 3'b000);
    idle(1);
  endtask

  task automatic test_overrun;
    ready_i = 1'b0;
    sb.push_back('{data: 3'b001, perr: 1'b0});
    send_frame(6'b010011);
    chk("ovr_first_valid", {2'b0, valid_o}, 3'b001);
    send_frame(6'b001011);
    chk("ovr_pulse", {2'b0, overrun_o}, 3'b001);
    chk("ovr_no_ferr", {2'b0, frame_err_o}, 3'b000);
    chk("ovr_hold_data", data_o, 3'b001);
    chk("ovr_hold_valid", {2'b0, valid_o}, 3'b001);
    idle(1);
    chk("ovr_once", {2'b0, overrun_o}, 3'b000);
    ready_i = 1'b1;
    idle(1);
    chk("ovr_drained", {2'b0, valid_o}, 3'b000);
  endtask

  task automatic test_back_to_back;
    ready_i = 1'b0;
    sb.push_back('{data: 3'b001, perr: 1'b0});
    send_frame(6'b010011);
    send_head(6'b001011);
    chk("b2b_valid_before", {2'b0, valid_o}, 3'b001);
    sb.push_back('{data: 3'b010, perr: 1'b0});
    ready_i = 1'b1;
    send_bit(1'b1);
    ready_i = 1'b0;
    chk("b2b_valid_after", {2'b0, valid_o}, 3'b001);
    chk("b2b_data", data_o, 3'b010);
    chk("b2b_no_ovr", {2'b0, overrun_o}, 3'b000);
    ready_i = 1'b1;
    idle(1);
    chk("b2b_drained", {2'b0, valid_o}, 3'b000);
  endtask

  task automatic test_gapped;
    logic [5:0] f;
    f       = 6'b011001;
    ready_i = 1'b1;
    repeat (4) send_bit(1'b1);
    chk("gap_idle_ones", {2'b0, valid_o}, 3'b000);
    sb.push_back('{data: 3'b011, perr: 1'b0});
    for (int i = 5; i >= 0; i--) begin
      if (i != 5) begin
        bit_i = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
      send_bit(f[i]);
    end
    chk("gap_valid", {2'b0, valid_o}, 3'b001);
    chk("gap_data", data_o, 3'b011);
    chk("gap_perr", {2'b0, parity_err_o}, 3'b000);
    idle(1);
  endtask

  task automatic test_reset_mid_frame;
    ready_i = 1'b0;
    send_frame(6'b011001);
    chk("mid_held", {2'b0, valid_o}, 3'b001);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_ni = 1'b0;
    idle(1);
    chk("mid_rst_data", data_o, 3'b000);
    chk("mid_rst_valid", {2'b0, valid_o}, 3'b000);
    chk("mid_rst_ferr", {2'b0, frame_err_o}, 3'b000);
    chk("mid_rst_ovr", {2'b0, overrun_o}, 3'b000);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    sb.push_back('{data: 3'b101, perr: 1'b0});
    send_frame(6'b010101);
    chk("mid_next_valid", {2'b0, valid_o}, 3'b001);
    chk("mid_next_data", data_o, 3'b101);
    chk("mid_next_perr", {2'b0, parity_err_o}, 3'b000);
    idle(2);
  endtask

  initial begin
    rst_ni        = 1'b0;
    bit_i         = 1'b1;
    bit_valid_i   = 1'b0;
    ready_i       = 1'b1;
    odd_bit       = 1'b1;
    odd_bit_valid = 1'b0;
    odd_ready     = 1'b1;
    test_reset();
    test_clean_frame();
    test_parity_error();
    test_odd_parity();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover: got %0d undelivered words want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
